// File: rtl/proc_multicycle_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// proc_multicycle_param : parametrised multi-cycle CPU, single shared bus.
// Optional macro PROC_SHIFT_EN enables sll/srl. Rev 1.0
// ---------------------------------------------------------------------------
module proc_multicycle_param #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] DIN,
    input  logic              Run,
    output logic              Done,
    output logic              Err,
    output logic [DATA_W-1:0] BusWires
);
    localparam int RSEL_W = $clog2(NREG);
    localparam int IR_W   = 4 + 2 * RSEL_W;
    localparam logic [DATA_W-1:0] C_DW  = DATA_W'(DATA_W);
    localparam logic [DATA_W-1:0] C_ONE = DATA_W'(1);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    step_t              step_q, step_d;
    logic [IR_W-1:0]    ir_q;
    logic [DATA_W-1:0]  regs_q [NREG];
    logic [DATA_W-1:0]  a_q, g_q;
    logic [DATA_W-1:0]  alu_d;
    logic [DATA_W-1:0]  bus_d;
    logic [3:0]         opcode;
    logic [RSEL_W-1:0]  rx, ry;
    logic               alu_op, rx_we, a_we, g_we, done_d, err_d;

    assign opcode = ir_q[3:0];
    assign rx     = ir_q[3+RSEL_W:4];
    assign ry     = ir_q[3+2*RSEL_W:4+RSEL_W];

    always_comb begin
        alu_op = (opcode >= 4'd2) && (opcode <= 4'd5);
`ifdef PROC_SHIFT_EN
        if ((opcode == 4'd6) || (opcode == 4'd7)) alu_op = 1'b1;
`endif
    end

    // ALU operand B is always the bus (Ry in T2)
    always_comb begin
        alu_d = '0;
        case (opcode)
            4'd2: alu_d = a_q + bus_d;
            4'd3: alu_d = a_q - bus_d;
            4'd4: alu_d = a_q & bus_d;
            4'd5: alu_d = (a_q < bus_d) ? C_ONE : '0;
`ifdef PROC_SHIFT_EN
            4'd6: alu_d = (bus_d >= C_DW) ? '0 : (a_q << bus_d);
            4'd7: alu_d = (bus_d >= C_DW) ? '0 : (a_q >> bus_d);
`endif
            default: alu_d = '0;
        endcase
    end

    always_comb begin
        step_d = step_q;
        bus_d  = '0;
        rx_we  = 1'b0;
        a_we   = 1'b0;
        g_we   = 1'b0;
        done_d = 1'b0;
        err_d  = 1'b0;
        case (step_q)
            T0: if (Run) step_d = T1;
            T1: begin
                if (opcode == 4'd0) begin
                    bus_d  = regs_q[ry];
                    rx_we  = 1'b1;
                    done_d = 1'b1;
                end else if (opcode == 4'd1) begin
                    bus_d  = DIN;
                    rx_we  = 1'b1;
                    done_d = 1'b1;
                end else if (alu_op) begin
                    bus_d  = regs_q[rx];
                    a_we   = 1'b1;
                    step_d = T2;
                end else if (opcode == 4'd8) begin
                    bus_d  = regs_q[ry];
                    rx_we  = (g_q != '0);
                    done_d = 1'b1;
                end else begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end
            end
            T2: begin
                bus_d  = regs_q[ry];
                g_we   = 1'b1;
                step_d = T3;
            end
            T3: begin
                bus_d  = g_q;
                rx_we  = 1'b1;
                done_d = 1'b1;
            end
            default: step_d = T0;
        endcase
        if (done_d) step_d = T0;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            step_q <= T0;
            ir_q   <= '0;
            a_q    <= '0;
            g_q    <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            step_q <= step_d;
            if ((step_q == T0) && Run) ir_q <= DIN[IR_W-1:0];
            if (a_we)  a_q <= bus_d;
            if (g_we)  g_q <= alu_d;
            if (rx_we) regs_q[rx] <= bus_d;
        end
    end

    assign Done     = done_d;
    assign Err      = err_d;
    assign BusWires = bus_d;

endmodule
`default_nettype wire

// File: tb/tb_proc_multicycle_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_proc_multicycle_param : directed + random bench with instruction-level model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_proc_multicycle_param;
    localparam int DW = 16;
    localparam int NR = 8;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          Run;
    logic [DW-1:0] DIN;
    logic          Done;
    logic          Err;
    logic [DW-1:0] BusWires;

    proc_multicycle_param #(.DATA_W(DW), .NREG(NR)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .DIN      (DIN),
        .Run      (Run),
        .Done     (Done),
        .Err      (Err),
        .BusWires (BusWires)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] m_r [NR];
    logic [DW-1:0] m_g;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit shift_en();
`ifdef PROC_SHIFT_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Run one instruction; checks the bus in every step, Done latency and Err.
    task automatic exec(input logic [3:0] op, input int x, input int y, input logic [DW-1:0] imm);
        logic [DW-1:0] din, a, b, res;
        logic [DW-1:0] exp_bus [4];
        bit            alu, illegal, got;
        int            steps, n;
        a   = m_r[x];
        b   = m_r[y];
        alu = ((op >= 2) && (op <= 5)) || (((op == 6) || (op == 7)) && shift_en());
        illegal = !((op <= 1) || (op == 8) || alu);
        case (op)
            4'd2:    res = a + b;
            4'd3:    res = a - b;
            4'd4:    res = a & b;
            4'd5:    res = (a < b) ? 16'd1 : 16'd0;
            4'd6:    res = (b >= DW) ? 16'd0 : (a << b);
            4'd7:    res = (b >= DW) ? 16'd0 : (a >> b);
            default: res = '0;
        endcase
        for (int i = 0; i < 4; i++) exp_bus[i] = '0;
        if (alu) begin
            steps = 3; exp_bus[1] = a; exp_bus[2] = b; exp_bus[3] = res;
        end else begin
            steps = 1;
            if ((op == 0) || (op == 8)) exp_bus[1] = b;
            else if (op == 1)           exp_bus[1] = imm;
        end
        din      = DW'($urandom);
        din[3:0] = op;
        din[6:4] = x[2:0];
        din[9:7] = y[2:0];
        Run = 1'b1;
        DIN = din;
        @(posedge Clock); #1;
        Run = 1'($urandom_range(0, 1));
        DIN = imm;
        n   = 0;
        got = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            #4;
            if (k <= 3) chk($sformatf("bus_op%0d_T%0d", op, k), BusWires, exp_bus[k]);
            if (Done) begin
                n   = k;
                got = 1'b1;
                chk($sformatf("err_op%0d", op), Err, illegal);
            end
            @(posedge Clock); #1;
            Run = 1'($urandom_range(0, 1));
            if (got) break;
        end
        Run = 1'b0;
        chk($sformatf("done_step_op%0d", op), n, steps);
        if (alu) begin
            m_r[x] = res;
            m_g    = res;
        end else if (op == 0) m_r[x] = b;
        else if (op == 1)     m_r[x] = imm;
        else if ((op == 8) && (m_g != 0)) m_r[x] = b;
    endtask

    task automatic readall();
        for (int i = 0; i < NR; i++) exec(4'd0, i, i, '0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_r[i] = '0;
        m_g = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        Reset = 1'b1;
        Run   = 1'b0;
        DIN   = '0;
        #2;
        chk("rst_done", Done, 1'b0);
        chk("rst_err", Err, 1'b0);
        chk("rst_bus", BusWires, '0);
        @(posedge Clock); #1;
        Reset = 1'b0;
        readall();

        // mvi/add
        exec(4'd1, 0, 0, 16'h0005);
        exec(4'd1, 1, 0, 16'h0003);
        exec(4'd2, 0, 1, '0);
        // sub, slt
        exec(4'd1, 0, 0, 16'h0003);
        exec(4'd1, 1, 0, 16'h0005);
        exec(4'd3, 0, 1, '0);
        exec(4'd5, 1, 0, '0);
        // shifts, including shift amount >= width
        exec(4'd1, 2, 0, 16'h8000);
        exec(4'd1, 3, 0, 16'd15);
        exec(4'd7, 2, 3, '0);
        exec(4'd1, 3, 0, 16'd17);
        exec(4'd6, 2, 3, '0);
        exec(4'd1, 2, 0, 16'h00F0);
        exec(4'd1, 3, 0, 16'd4);
        exec(4'd6, 2, 3, '0);
        readall();
        // illegal and mvnz with G zero / non-zero
        exec(4'd15, 0, 0, '0);
        exec(4'd9, 3, 5, '0);
        exec(4'd1, 6, 0, 16'd7);
        exec(4'd1, 7, 0, 16'd7);
        exec(4'd3, 6, 7, '0);
        exec(4'd1, 4, 0, 16'h1234);
        exec(4'd1, 5, 0, 16'h5678);
        exec(4'd8, 4, 5, '0);
        exec(4'd1, 6, 0, 16'd5);
        exec(4'd1, 7, 0, 16'd3);
        exec(4'd2, 6, 7, '0);
        exec(4'd8, 4, 5, '0);
        exec(4'd2, 0, 0, '0);
        readall();

        // reset in T2 of an add aborts with no write
        exec(4'd1, 1, 0, 16'h00AA);
        Run = 1'b1;
        DIN = 16'h0082;
        @(posedge Clock); #1;
        Run = 1'b0;
        @(posedge Clock); #1;
        chk("t2_bus_before_reset", BusWires, m_r[1]);
        Reset = 1'b1;
        #1;
        chk("midrst_done", Done, 1'b0);
        chk("midrst_bus", BusWires, '0);
        @(posedge Clock); #1;
        Reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            #4;
            chk("idle_bus", BusWires, '0);
            chk("idle_done", Done, 1'b0);
            @(posedge Clock); #1;
        end
        readall();

        // random instruction stream
        for (int i = 0; i < NR; i++) exec(4'd1, i, 0, DW'($urandom));
        for (int n = 0; n < 300; n++) begin
            logic [DW-1:0] imm;
            imm = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 20)) : DW'($urandom);
            exec(4'($urandom_range(0, 15)), $urandom_range(0, NR - 1), $urandom_range(0, NR - 1), imm);
            if ((n % 50) == 49) readall();
        end
        readall();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
